// File: rtl/xor_parity_rx_if.sv
// Serial receiver bundle: strobe and line in, buffered word out.
// The master drives the line and consumes words; the slave is the receiver.
interface xor_parity_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  bit_en;
  logic                  rx;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    output bit_en,
    output rx,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  bit_en,
    input  rx,
    input  data_ready,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start, LSB-first data, XOR parity, stop.
// Completed words sit in a one-entry valid/ready buffer.
module xor_parity_rx #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  xor_parity_rx_if.slave bus
);

  localparam int CW =
    (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par;
  logic                  perr;

  logic start_hit;
  logic data_hit;
  logic par_hit;
  logic stop_hit;
  logic busy_c;

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  ovr_q;

  logic buf_free;
  logic load;
  logic accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: advance only on strobe cycles
  always_comb begin
    state_nxt = state;
    if (bus.bit_en) begin
      unique case (state)
        IDLE: begin
          if (!bus.rx) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            state_nxt = PARITY;
          end
        end
        PARITY: state_nxt = STOP;
        STOP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state strobes that steer the datapath
  always_comb begin
    start_hit = 1'b0;
    data_hit  = 1'b0;
    par_hit   = 1'b0;
    stop_hit  = 1'b0;
    busy_c    = 1'b1;
    unique case (state)
      IDLE: begin
        start_hit = bus.bit_en & ~bus.rx;
        busy_c    = 1'b0;
      end
      DATA:   data_hit = bus.bit_en;
      PARITY: par_hit  = bus.bit_en;
      STOP:   stop_hit = bus.bit_en;
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // Deserialiser with running XOR parity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      shift <= '0;
      par   <= 1'b0;
      perr  <= 1'b0;
    end else if (start_hit) begin
      cnt   <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else if (data_hit) begin
      shift <= {bus.rx, shift[DATA_WIDTH-1:1]};
      par   <= par ^ bus.rx;
      cnt   <= cnt + 1'b1;
    end else if (par_hit) begin
      perr  <= par ^ bus.rx ^ PARITY_ODD;
    end
  end

  assign accept   = valid_q & bus.data_ready;
  assign buf_free = ~valid_q | bus.data_ready;
  assign load     = stop_hit & buf_free;

  // One-entry output buffer and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (load) begin
      dout_q  <= shift;
      perr_q  <= perr;
      ferr_q  <= ~bus.rx;
      valid_q <= 1'b1;
    end else begin
      if (stop_hit) begin
        ovr_q <= 1'b1;
      end
      if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_c;

endmodule
